// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC   = 8'hA5;
  localparam int         WORD_W         = 32;
  localparam int         BYTES_PER_WORD = 4;

  // Running frame checksum is a plain XOR fold over the payload bytes.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Big-endian byte-to-word packer: lane counter, shift register, word-complete pulse.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rstd,
  input  logic              clear,
  input  logic              shift,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  logic [1:0]        lane;
  logic [WORD_W-1:0] shreg;

  // The word is presented combinationally so the 4th byte lands in the same edge's write.
  assign word      = {shreg[WORD_W-9:0], din};
  assign word_done = shift && (lane == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rstd) begin
      lane  <= 2'd0;
      shreg <= '0;
    end else if (clear) begin
      lane  <= 2'd0;
      shreg <= '0;
    end else if (shift) begin
      lane  <= lane + 2'd1;
      shreg <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing 32-bit words to instruction memory and gating CPU reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC,
  parameter int         ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_rstd,
  output logic              done,
  output logic              err
);

  state_t              state, state_next;
  logic                accept, is_sync, pack_clear, pack_shift, word_done;
  logic [WORD_W-1:0]   pack_word;
  logic [ADDR_W-1:0]   word_idx;
  logic [8:0]          words_left;
  logic [7:0]          csum;

  assign in_ready   = rstd;
  assign accept     = in_valid && in_ready;
  assign is_sync    = (in_data == SYNC_BYTE);
  assign pack_clear = accept && (state == ST_COUNT);
  assign pack_shift = accept && (state == ST_DATA);

  word_packer u_packer (
    .clk       (clk),
    .rstd      (rstd),
    .clear     (pack_clear),
    .shift     (pack_shift),
    .din       (in_data),
    .word      (pack_word),
    .word_done (word_done)
  );

  always_ff @(posedge clk) begin
    if (!rstd) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        ST_IDLE:  state_next = is_sync ? ST_COUNT : ST_IDLE;
        ST_COUNT: state_next = ST_DATA;
        ST_DATA:  state_next = (word_done && (words_left == 9'd1)) ? ST_CHECK : ST_DATA;
        ST_CHECK: state_next = (in_data == csum) ? ST_RUN : ST_ERROR;
        ST_RUN:   state_next = is_sync ? ST_COUNT : ST_RUN;
        ST_ERROR: state_next = is_sync ? ST_COUNT : ST_ERROR;
        default:  state_next = ST_IDLE;
      endcase
    end else begin
      state_next = state;
    end
  end

  // Count byte 0 stands for a full 256-word image.
  always_ff @(posedge clk) begin
    if (!rstd) begin
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_rstd   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_idx   <= '0;
      words_left <= 9'd0;
      csum       <= 8'd0;
    end else begin
      im_we <= word_done;
      if (word_done) begin
        im_addr    <= word_idx;
        im_wdata   <= pack_word;
        word_idx   <= word_idx + ADDR_W'(1);
        words_left <= words_left - 9'd1;
      end
      if (pack_clear) begin
        word_idx   <= '0;
        csum       <= 8'd0;
        words_left <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
      end else if (pack_shift) begin
        csum <= csum_step(csum, in_data);
      end
      done     <= (state_next == ST_RUN);
      cpu_rstd <= (state_next == ST_RUN);
      err      <= (state_next == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames built from word lists, writes checked against a queue model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rstd = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, im_we, cpu_rstd, done, err;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;

  int tests = 0;
  int fails = 0;

  logic [39:0] obs_q[$];
  logic [39:0] exp_q[$];
  logic [7:0]  byte_q[$];
  logic [7:0]  garb_q[$];
  logic [31:0] words[$];
  logic        exp_good;

  always #5 clk = ~clk;

  imem_loader #(.SYNC_BYTE(8'hA5), .ADDR_W(8)) dut (
    .clk(clk), .rstd(rstd), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rstd(cpu_rstd), .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (im_we === 1'b1) obs_q.push_back({im_addr, im_wdata});
  end

  // Model: garbage, sync, count, words big-endian, XOR of all data bytes (optionally corrupted).
  task automatic build_frame(input bit corrupt);
    logic [31:0] fold;
    logic [7:0]  ck;
    byte_q.delete();
    foreach (garb_q[i]) byte_q.push_back(garb_q[i]);
    garb_q.delete();
    byte_q.push_back(8'hA5);
    byte_q.push_back(8'(words.size()));
    fold = 32'h0;
    foreach (words[i]) begin
      fold = fold ^ words[i];
      byte_q.push_back(words[i][31:24]);
      byte_q.push_back(words[i][23:16]);
      byte_q.push_back(words[i][15:8]);
      byte_q.push_back(words[i][7:0]);
      exp_q.push_back({8'(i), words[i]});
    end
    ck = fold[31:24] ^ fold[23:16] ^ fold[15:8] ^ fold[7:0];
    if (corrupt) ck = ck ^ 8'h01;
    byte_q.push_back(ck);
    exp_good = !corrupt;
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic send_frame(input int stall_at, input string name);
    for (int i = 0; i < byte_q.size(); i++) begin
      if (i == stall_at) begin
        repeat (3) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = byte_q[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (done !== exp_good || cpu_rstd !== exp_good || err !== !exp_good) begin
      fails++;
      $display("FAIL %s status: done=%b cpu_rstd=%b err=%b, expected done=%b cpu_rstd=%b err=%b",
               name, done, cpu_rstd, err, exp_good, exp_good, !exp_good);
    end
  endtask

  task automatic check_writes(input string name);
    repeat (2) @(negedge clk);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s write count: got %0d, expected %0d", name, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL %s write %0d: got addr=%h data=%h, expected addr=%h data=%h",
                   name, i, obs_q[i][39:32], obs_q[i][31:0], exp_q[i][39:32], exp_q[i][31:0]);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    tests++;
    if (im_we !== 1'b0 || im_addr !== 8'h00 || im_wdata !== 32'h0 ||
        cpu_rstd !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL %s outputs: we=%b addr=%h wdata=%h cpu_rstd=%b done=%b err=%b, expected all 0",
               name, im_we, im_addr, im_wdata, cpu_rstd, done, err);
    end
  endtask

  task automatic test_reset();
    rstd = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset in_ready: got %b, expected 0", in_ready);
    end
    rstd = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready after reset: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_good_single();
    words.delete();
    words.push_back(32'hDEADBEEF);
    build_frame(1'b0);
    tests++;
    if (byte_q[6] !== 8'h22) begin
      fails++;
      $display("FAIL model checksum: got %h, expected 22", byte_q[6]);
    end
    send_frame(-1, "good_single");
    check_writes("good_single");
  endtask

  task automatic test_bad_and_recover();
    words.delete();
    words.push_back(32'hDEADBEEF);
    build_frame(1'b1);
    send_frame(-1, "bad_csum");
    check_writes("bad_csum");
    words.delete();
    words.push_back(32'h00000001);
    build_frame(1'b0);
    send_frame(-1, "recover");
    check_writes("recover");
  endtask

  task automatic test_garbage_stall();
    garb_q.push_back(8'h00);
    garb_q.push_back(8'hFF);
    garb_q.push_back(8'h3C);
    rand_words(2);
    build_frame(1'b0);
    send_frame(3 + 2 + 2, "garbage_stall");
    check_writes("garbage_stall");
  endtask

  task automatic test_count_zero();
    rand_words(256);
    build_frame(1'b0);
    send_frame(-1, "count_zero");
    check_writes("count_zero");
  endtask

  task automatic test_reset_mid_frame();
    rand_words(2);
    build_frame(1'b0);
    void'(exp_q.pop_back());
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = byte_q[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    rstd     = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midreset in_ready: got %b, expected 0", in_ready);
    end
    @(negedge clk);
    rstd = 1'b1;
    check_zero_outputs("midreset");
    check_writes("midreset_partial");
    rand_words(2);
    build_frame(1'b0);
    send_frame(-1, "after_midreset");
    check_writes("after_midreset");
  endtask

  task automatic test_reload();
    tests++;
    if (cpu_rstd !== 1'b1 || done !== 1'b1) begin
      fails++;
      $display("FAIL reload precondition: cpu_rstd=%b done=%b, expected 1 1", cpu_rstd, done);
    end
    rand_words(3);
    build_frame(1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = byte_q.pop_front();
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (cpu_rstd !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reload fall: cpu_rstd=%b done=%b, expected 0 0", cpu_rstd, done);
    end
    send_frame(-1, "reload");
    check_writes("reload");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        garb_q.push_back(b);
      end
      rand_words(n);
      build_frame(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
      send_frame(($urandom_range(0, 1) == 1) ? $urandom_range(0, byte_q.size() - 1) : -1, "b2b");
      check_writes("b2b");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_single();
    test_bad_and_recover();
    test_garbage_stall();
    test_count_zero();
    test_reset_mid_frame();
    test_reload();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader and the writer side of the instruction memory that the fetch stage reads. It takes a framed byte stream over a valid/ready handshake, packs bytes into 32-bit instruction words, and writes them to consecutive word addresses of instruction memory. It keeps the CPU in reset until a frame loads with a correct checksum. It sits between the host byte link and the `computer` top level, and drives that level's `rstd`.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `ADDR_W`, default 8: instruction-memory word-address width (256 words).
- `clk`  in  1: single clock, rising edge.
- `rstd`  in  1: reset, synchronous, active-low.
- `in_data`  in  8: stream byte.
- `in_valid`  in  1: `in_data` valid.
- `in_ready`  out  1: loader can accept a byte.
- `im_we`  out  1: instruction-memory write strobe, one cycle per word.
- `im_addr`  out  ADDR_W: word address for the write.
- `im_wdata`  out  32: instruction word.
- `cpu_rstd`  out  1: active-low reset to the CPU.
- `done`  out  1: last frame loaded and verified.
- `err`  out  1: last frame failed its checksum.

## Operation
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- `in_ready` is 1 in every state while `rstd` is 1, and 0 while `rstd` is 0.
- Frame format: `SYNC_BYTE`, then count byte N, then 4·N data bytes, then a checksum byte.
  - N = 0 means 256 words.
  - Checksum = XOR of all data bytes; the sync and count bytes are excluded.
- Packing is big-endian: the first byte of each group of four goes to `im_wdata[31:24]`.
- States:
  - IDLE: discard bytes other than `SYNC_BYTE`. On `SYNC_BYTE` go to COUNT.
  - COUNT: latch N, clear word index, byte lane and running XOR. Go to DATA.
  - DATA: shift each byte into the word register and XOR it into the checksum. On the 4th byte, issue a write and advance the word index. After the last word, go to CHECK.
  - CHECK: compare the received byte with the running XOR. On match go to RUN; on mismatch go to ERROR.
  - RUN: `done`=1 and `cpu_rstd`=1. Non-sync bytes are discarded. `SYNC_BYTE` starts a reload: go to COUNT, and `done` and `cpu_rstd` go to 0.
  - ERROR: `err`=1 and `cpu_rstd`=0. Non-sync bytes are discarded. `SYNC_BYTE` goes to COUNT and clears `err`.
- The word index is ADDR_W bits and wraps from 255 to 0.
- A failed frame does not roll back words already written. Memory keeps whatever was written.
- `SYNC_BYTE` is not special inside COUNT, DATA or CHECK; there it is treated as ordinary payload.

## Timing
- Reset (`rstd`=0 at an edge) sets every output to 0: `im_we`, `im_addr`, `im_wdata`, `cpu_rstd`, `done`, `err`. State becomes IDLE. Any partial word and checksum are discarded.
- After reset the CPU stays held (`cpu_rstd`=0) until a good frame completes.
- `im_we` is registered. It is high for exactly the one cycle after the edge that accepts the 4th byte of a word. In that cycle `im_addr` is the word index and `im_wdata` is the packed word.
- The first word goes to address 0 and word k goes to address k mod 256.
- Back-to-back bytes at one per cycle are sustained, giving one write every 4 cycles. Gaps in `in_valid` stall packing without corrupting it.
- `done`, `cpu_rstd` and `err` change in the cycle after the checksum byte is accepted.
- On a reload `SYNC_BYTE` accepted in RUN, `cpu_rstd` falls in the cycle after acceptance.
- `im_addr` and `im_wdata` hold their last values when `im_we` is 0.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum (IDLE, COUNT, DATA, CHECK, RUN, ERROR);
  - the default `SYNC_BYTE`;
  - the word width (32) and bytes-per-word constant (4).
- Sub-module `word_packer` contains the byte-lane counter, the 32-bit shift register and the word-complete pulse. The FSM, word index and checksum stay in `imem_loader`.

## Test plan
- Good single-word frame:
  - Stimulus: after reset, send A5,01,DE,AD,BE,EF,22 back-to-back.
  - Required: one `im_we` pulse with `im_addr`=0 and `im_wdata`=32'hDEADBEEF; then `done`=1, `cpu_rstd`=1, `err`=0.
- Bad checksum and recovery:
  - Stimulus: send the same frame with checksum 23.
  - Required: `err`=1, `cpu_rstd`=0, `done`=0.
  - Stimulus: then send A5,01,00,00,00,01,01.
  - Required: write of 32'h00000001 to address 0, `done`=1, `err`=0.
- Leading garbage and stalls:
  - Stimulus: send 00,FF,3C before A5,02 plus 8 data bytes, with `in_valid` dropping for 3 cycles mid-word.
  - Required: the garbage is ignored; exactly two writes, to addresses 0 and 1, with the correct words.
- Count 00:
  - Stimulus: send 1024 data bytes with the correct XOR.
  - Required: 256 writes to addresses 0..255 in order, then `done`=1.
- Reset mid-frame:
  - Stimulus: assert `rstd`=0 for one cycle after byte 6 of a 2-word frame.
  - Required: all outputs return to 0. A new frame then loads starting at address 0.
- Reload from RUN:
  - Stimulus: in RUN, send A5.
  - Required: `cpu_rstd` and `done` fall the next cycle. The following frame overwrites from address 0.
